regfile_wb_arbiter: RTL

//   Shares the single register-file write port (WE/aw/din) among NREQ write-back

---
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port among NREQ write-back requesters, with a pending-write scoreboard
// Ports: clk, rst_n (async active-low); req_valid/req_addr/req_data in, req_ready one-hot grant out;
// WE/aw/din registered regfile write; sb_set/sb_addr mark a destination pending;
// q1_addr/q2_addr query the scoreboard, q1_pend/q2_pend combinational answers.
// Build option WB_RR_EN: round-robin grant; undefined gives fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic             WE,
  output logic [AW-1:0]      aw,
  output logic [DW-1:0]      din,
  input  logic             sb_set,
  input  logic [AW-1:0]      sb_addr,
  input  logic [AW-1:0]      q1_addr,
  input  logic [AW-1:0]      q2_addr,
  output logic             q1_pend,
  output logic             q2_pend
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0] gidx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic xfer;
  logic [NR-1:0] pending, pend_nxt;
`ifdef WB_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [PW:0] idx;
  // descending search so the candidate nearest rr_ptr is assigned last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = (idx >= (PW+1)'(NREQ)) ? idx - (PW+1)'(NREQ) : idx;
      if (req_valid[idx[PW-1:0]]) gnt = NREQ'(1) << idx[PW-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (xfer) rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`else
  always_comb begin
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (req_valid[k]) gnt = NREQ'(1) << k;
  end
`endif
  assign req_ready = rst_n ? gnt : '0;
  assign xfer = |req_ready;
  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++) if (gnt[k]) gidx = PW'(k);
  end
  assign sel_addr = req_addr[gidx*AW +: AW];
  assign sel_data = req_data[gidx*DW +: DW];
  // set is applied after clear so a newly issued producer keeps the register pending
  always_comb begin
    pend_nxt = pending;
    if (xfer && sel_addr != '0) pend_nxt[sel_addr] = 1'b0;
    if (sb_set && sb_addr != '0) pend_nxt[sb_addr] = 1'b1;
  end
  assign q1_pend = (q1_addr != '0) && pending[q1_addr];
  assign q2_pend = (q2_addr != '0) && pending[q2_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WE <= 1'b0;
      aw <= '0;
      din <= '0;
      pending <= '0;
    end else begin
      WE <= xfer && sel_addr != '0;
      if (xfer) begin
        aw <= sel_addr;
        din <= sel_data;
      end
      pending <= pend_nxt;
    end
endmodule
